param_fifo: RTL and testbench

- Parametrised synchronous FIFO; next generation of the team's 8-deep FIFO.
- Generalised in width, depth and almost-flag thresholds.
- Adds a first-word-fall-through (FWFT) read mode, a synchronous flush and an occupancy count.
- Sits between the server request path and user-processing stages; instanced once per channel.

---
 rtl/fifo_pkg.sv | 22 ++
 rtl/param_fifo_if.sv | 36 +++
 rtl/fifo_ptr_ctrl.sv | 103 ++++++++++
 rtl/param_fifo.sv | 83 ++++++++
 tb/tb_param_fifo.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_pkg : shared types, defaults and sizing helper for param_fifo   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_DEPTH      = 8;

  // Occupancy must be able to represent DEPTH itself, hence depth+1.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/param_fifo_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | param_fifo_if : write/read/status bundle of one FIFO channel         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface param_fifo_if #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_W      = 4
);
  logic                  flush;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  full;
  logic                  empty;
  logic                  almostfull;
  logic                  almostempty;
  logic                  wr_ack;
  logic                  overflow;
  logic                  underflow;
  logic [CNT_W-1:0]      count;

  modport master (
    output flush, wr_en, data_in, rd_en,
    input  data_out, full, empty, almostfull, almostempty,
    input  wr_ack, overflow, underflow, count
  );

  modport slave (
    input  flush, wr_en, data_in, rd_en,
    output data_out, full, empty, almostfull, almostempty,
    output wr_ack, overflow, underflow, count
  );
endinterface
`default_nettype wire

// File: rtl/fifo_ptr_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_ptr_ctrl : accept logic, wrapping pointers, count, status pulses|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fifo_ptr_ctrl #(
  parameter int DEPTH = 8,
  parameter int AF_TH = 7,
  parameter int AE_TH = 1,
  parameter int FWFT  = 0,
  parameter int PTR_W = 3,
  parameter int CNT_W = 4
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_flush,
  input  wire logic             i_wr_en,
  input  wire logic             i_rd_en,
  output logic [PTR_W-1:0]      o_wr_ptr,
  output logic [PTR_W-1:0]      o_rd_ptr,
  output logic                  o_wr_fire,
  output logic                  o_rd_fire,
  output logic [CNT_W-1:0]      o_count,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_almostfull,
  output logic                  o_almostempty,
  output logic                  o_wr_ack,
  output logic                  o_overflow,
  output logic                  o_underflow
);
  localparam logic [PTR_W-1:0] c_ptr_last = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] c_cnt_full = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] c_cnt_af   = CNT_W'(AF_TH);
  localparam logic [CNT_W-1:0] c_cnt_ae   = CNT_W'(AE_TH);
  localparam bit               c_fwft     = (FWFT != 0);

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_wr_ack;
  logic             r_overflow;
  logic             r_underflow;
  logic             w_full;
  logic             w_empty;
  logic             w_wr_fire;
  logic             w_rd_fire;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == c_ptr_last) ? '0 : p + 1'b1;
  endfunction

  assign w_full    = (r_count == c_cnt_full);
  assign w_empty   = (r_count == '0);
  // In FWFT mode a full FIFO can take a write when the head is popped alongside.
  assign w_wr_fire = i_wr_en && !i_flush && (!w_full || (c_fwft && i_rd_en));
  assign w_rd_fire = i_rd_en && !i_flush && !w_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_wr_ack    <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (i_flush) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_wr_ack    <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_fire) r_wr_ptr <= ptr_next(r_wr_ptr);
      if (w_rd_fire) r_rd_ptr <= ptr_next(r_rd_ptr);
      if (w_wr_fire && !w_rd_fire) begin
        r_count <= r_count + 1'b1;
      end else if (!w_wr_fire && w_rd_fire) begin
        r_count <= r_count - 1'b1;
      end
      r_wr_ack    <= w_wr_fire;
      r_overflow  <= i_wr_en && !w_wr_fire;
      r_underflow <= i_rd_en && !w_rd_fire;
    end
  end

  assign o_wr_ptr      = r_wr_ptr;
  assign o_rd_ptr      = r_rd_ptr;
  assign o_wr_fire     = w_wr_fire;
  assign o_rd_fire     = w_rd_fire;
  assign o_count       = r_count;
  assign o_full        = w_full;
  assign o_empty       = w_empty;
  assign o_almostfull  = (r_count >= c_cnt_af);
  assign o_almostempty = (r_count <= c_cnt_ae);
  assign o_wr_ack      = r_wr_ack;
  assign o_overflow    = r_overflow;
  assign o_underflow   = r_underflow;

endmodule
`default_nettype wire

// File: rtl/param_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | param_fifo : parametrised synchronous FIFO, standard or FWFT read    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module param_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int AF_TH      = 7,
  parameter int AE_TH      = 1,
  parameter int FWFT       = 0
) (
  input  wire logic   clk,
  input  wire logic   rst,
  param_fifo_if.slave bus
);
  localparam int         c_ptr_w = $clog2(DEPTH);
  localparam int         c_cnt_w = cnt_width(DEPTH);
  localparam fifo_mode_e c_mode  = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [c_ptr_w-1:0]    w_wr_ptr;
  logic [c_ptr_w-1:0]    w_rd_ptr;
  logic                  w_wr_fire;
  logic                  w_rd_fire;
  logic                  w_empty;
  logic [c_cnt_w-1:0]    w_count;

  fifo_ptr_ctrl #(
    .DEPTH (DEPTH),
    .AF_TH (AF_TH),
    .AE_TH (AE_TH),
    .FWFT  (FWFT),
    .PTR_W (c_ptr_w),
    .CNT_W (c_cnt_w)
  ) u_ctrl (
    .clk           (clk),
    .rst           (rst),
    .i_flush       (bus.flush),
    .i_wr_en       (bus.wr_en),
    .i_rd_en       (bus.rd_en),
    .o_wr_ptr      (w_wr_ptr),
    .o_rd_ptr      (w_rd_ptr),
    .o_wr_fire     (w_wr_fire),
    .o_rd_fire     (w_rd_fire),
    .o_count       (w_count),
    .o_full        (bus.full),
    .o_empty       (w_empty),
    .o_almostfull  (bus.almostfull),
    .o_almostempty (bus.almostempty),
    .o_wr_ack      (bus.wr_ack),
    .o_overflow    (bus.overflow),
    .o_underflow   (bus.underflow)
  );

  assign bus.empty = w_empty;
  assign bus.count = w_count;

  // Storage is not reset; contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (w_wr_fire) r_mem[w_wr_ptr] <= bus.data_in;
  end

  generate
    if (c_mode == FIFO_FWFT) begin : g_fwft
      assign bus.data_out = w_empty ? '0 : r_mem[w_rd_ptr];
    end else begin : g_std
      logic [DATA_WIDTH-1:0] r_data_out;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_data_out <= '0;
        end else if (w_rd_fire) begin
          r_data_out <= r_mem[w_rd_ptr];
        end
      end
      assign bus.data_out = r_data_out;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_param_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_param_fifo : three FIFO configurations against a queue model      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_param_fifo;
  import fifo_pkg::*;

  localparam int NCFG = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr  [NCFG];
  logic        rd  [NCFG];
  logic        fl  [NCFG];
  logic [15:0] din [NCFG];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // cfg0: DEPTH 8 standard, cfg1: DEPTH 8 FWFT, cfg2: DEPTH 6 standard
  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int D  = (g == 2) ? 6 : 8;
    localparam int FW = (g == 1) ? 1 : 0;
    localparam int AF = (g == 2) ? 4 : 7;
    localparam int AE = (g == 2) ? 2 : 1;
    localparam int CW = cnt_width(D);

    param_fifo_if #(.DATA_WIDTH(16), .CNT_W(CW)) ifc ();
    assign ifc.flush   = fl[g];
    assign ifc.wr_en   = wr[g];
    assign ifc.rd_en   = rd[g];
    assign ifc.data_in = din[g];

    param_fifo #(
      .DATA_WIDTH (16),
      .DEPTH      (D),
      .AF_TH      (AF),
      .AE_TH      (AE),
      .FWFT       (FW)
    ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
    );

    int q[$];
    int m_dout, m_pop, exp_dout, max_cnt;
    bit m_ack, m_ov, m_un, wa, ra;

    initial begin
      m_dout = 0; m_ack = 0; m_ov = 0; m_un = 0; max_cnt = 0;
      forever begin
        @(posedge clk);
        if (!rst) begin
          if (fl[g]) begin
            q.delete();
            m_ack = 0; m_ov = 0; m_un = 0;
          end else begin
            ra = rd[g] && (q.size() > 0);
            wa = wr[g] && ((q.size() < D) || (FW == 1 && rd[g]));
            if (ra) begin
              m_pop = q.pop_front();
              if (FW == 0) m_dout = m_pop;
            end
            if (wa) q.push_back(int'(din[g]));
            m_ack = wa;
            m_ov  = wr[g] && !wa;
            m_un  = rd[g] && !ra;
          end
        end
        @(negedge clk);
        if (rst) begin
          q.delete();
          m_dout = 0; m_ack = 0; m_ov = 0; m_un = 0;
        end
        if (int'(ifc.count) > max_cnt) max_cnt = int'(ifc.count);
        exp_dout = (FW == 1) ? ((q.size() > 0) ? q[0] : 0) : m_dout;
        chk($sformatf("c%0d count", g), int'(ifc.count), q.size());
        chk($sformatf("c%0d full", g), int'(ifc.full), int'(q.size() == D));
        chk($sformatf("c%0d empty", g), int'(ifc.empty), int'(q.size() == 0));
        chk($sformatf("c%0d almostfull", g), int'(ifc.almostfull), int'(q.size() >= AF));
        chk($sformatf("c%0d almostempty", g), int'(ifc.almostempty), int'(q.size() <= AE));
        chk($sformatf("c%0d wr_ack", g), int'(ifc.wr_ack), int'(m_ack));
        chk($sformatf("c%0d overflow", g), int'(ifc.overflow), int'(m_ov));
        chk($sformatf("c%0d underflow", g), int'(ifc.underflow), int'(m_un));
        chk($sformatf("c%0d data_out", g), int'(ifc.data_out), exp_dout);
      end
    end
  end

  typedef struct {
    bit          wr, rd, fl;
    logic [15:0] d;
    int          cnt;
    bit          full, empty, ack, ov, un;
    logic [15:0] dout;
  } vec_t;

  vec_t vt [21];

  task automatic idle_all();
    for (int c = 0; c < NCFG; c++) begin
      wr[c] = 1'b0; rd[c] = 1'b0; fl[c] = 1'b0; din[c] = 16'h0;
    end
  endtask

  // Advance one clock; returns at negedge+1 where inputs change and outputs are sampled.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    idle_all();
    rst = 1'b1;
    repeat (2) tick();
    chk("reset count", int'(g_cfg[0].ifc.count), 0);
    chk("reset empty", int'(g_cfg[0].ifc.empty), 1);
    chk("reset almostempty", int'(g_cfg[0].ifc.almostempty), 1);
    chk("reset full", int'(g_cfg[0].ifc.full), 0);
    chk("reset data_out", int'(g_cfg[0].ifc.data_out), 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++)
      vt[i] = '{1'b1, 1'b0, 1'b0, 16'(i + 1), i + 1, (i == 7), 1'b0, 1'b1, 1'b0, 1'b0, 16'h0};
    vt[8] = '{1'b1, 1'b0, 1'b0, 16'h0009, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0};
    for (int i = 0; i < 8; i++)
      vt[9 + i] = '{1'b0, 1'b1, 1'b0, 16'h0, 7 - i, 1'b0, (i == 7), 1'b0, 1'b0, 1'b0, 16'(i + 1)};
    vt[17] = '{1'b0, 1'b1, 1'b0, 16'h0000, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0008};
    vt[18] = '{1'b1, 1'b1, 1'b0, 16'h00AA, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0008};
    vt[19] = '{1'b1, 1'b1, 1'b0, 16'h00BB, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h00AA};
    vt[20] = '{1'b1, 1'b0, 1'b1, 16'h00CC, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h00AA};

    for (int i = 0; i < 21; i++) begin
      wr[0] = vt[i].wr; rd[0] = vt[i].rd; fl[0] = vt[i].fl; din[0] = vt[i].d;
      tick();
      chk($sformatf("vec%0d count", i), int'(g_cfg[0].ifc.count), vt[i].cnt);
      chk($sformatf("vec%0d full", i), int'(g_cfg[0].ifc.full), int'(vt[i].full));
      chk($sformatf("vec%0d empty", i), int'(g_cfg[0].ifc.empty), int'(vt[i].empty));
      chk($sformatf("vec%0d almostfull", i), int'(g_cfg[0].ifc.almostfull), int'(vt[i].cnt >= 7));
      chk($sformatf("vec%0d wr_ack", i), int'(g_cfg[0].ifc.wr_ack), int'(vt[i].ack));
      chk($sformatf("vec%0d overflow", i), int'(g_cfg[0].ifc.overflow), int'(vt[i].ov));
      chk($sformatf("vec%0d underflow", i), int'(g_cfg[0].ifc.underflow), int'(vt[i].un));
      chk($sformatf("vec%0d data_out", i), int'(g_cfg[0].ifc.data_out), int'(vt[i].dout));
    end
    idle_all();

    // Full with simultaneous write+read: standard reads only once, FWFT does both
    for (int i = 0; i < 8; i++) begin
      wr[0] = 1'b1; din[0] = 16'(16'h0100 + i);
      wr[1] = 1'b1; din[1] = 16'(16'h0200 + i);
      tick();
    end
    chk("fill c0 full", int'(g_cfg[0].ifc.full), 1);
    chk("fill c1 full", int'(g_cfg[1].ifc.full), 1);
    for (int i = 0; i < 10; i++) begin
      wr[0] = 1'b1; rd[0] = 1'b1; din[0] = 16'(16'h0300 + i);
      wr[1] = 1'b1; rd[1] = 1'b1; din[1] = 16'(16'h0400 + i);
      tick();
      chk($sformatf("fullrw%0d c0 count", i), int'(g_cfg[0].ifc.count), 7);
      chk($sformatf("fullrw%0d c0 overflow", i), int'(g_cfg[0].ifc.overflow), int'(i == 0));
      chk($sformatf("fullrw%0d c1 count", i), int'(g_cfg[1].ifc.count), 8);
      chk($sformatf("fullrw%0d c1 overflow", i), int'(g_cfg[1].ifc.overflow), 0);
    end
    idle_all();

    // Flush at half full
    fl[0] = 1'b1; tick(); fl[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr[0] = 1'b1; din[0] = 16'(16'h0500 + i); tick();
    end
    wr[0] = 1'b0;
    chk("half count", int'(g_cfg[0].ifc.count), 4);
    fl[0] = 1'b1; tick(); fl[0] = 1'b0;
    chk("flush count", int'(g_cfg[0].ifc.count), 0);
    chk("flush empty", int'(g_cfg[0].ifc.empty), 1);

    // Async reset in the middle of a write; the retried write must land in entry 0
    for (int i = 0; i < 3; i++) begin
      wr[0] = 1'b1; din[0] = 16'(16'h0600 + i); tick();
    end
    din[0] = 16'h0055;
    #2 rst = 1'b1;
    #1 chk("async rst count", int'(g_cfg[0].ifc.count), 0);
    tick();
    rst = 1'b0;
    tick();
    wr[0] = 1'b0;
    chk("post rst count", int'(g_cfg[0].ifc.count), 1);
    chk("post rst entry0", int'(g_cfg[0].u_dut.r_mem[0]), 16'h0055);

    // DEPTH 6: alternating write/read pairs wrap the pointers several times
    fl[2] = 1'b1; tick(); fl[2] = 1'b0;
    for (int k = 0; k < 20; k++) begin
      wr[2] = 1'b1; din[2] = 16'(16'h0700 + k); tick();
      wr[2] = 1'b0; rd[2] = 1'b1; tick();
      rd[2] = 1'b0;
      chk($sformatf("wrap%0d data_out", k), int'(g_cfg[2].ifc.data_out), 16'h0700 + k);
    end

    // Randomised traffic on all configurations with drifting fill bias
    for (int n = 0; n < 3000; n++) begin
      int bias;
      bias = ((n / 150) % 2 == 0) ? 70 : 30;
      for (int c = 0; c < NCFG; c++) begin
        wr[c]  = ($urandom_range(0, 99) < bias);
        rd[c]  = ($urandom_range(0, 99) < (100 - bias));
        fl[c]  = ($urandom_range(0, 249) == 0);
        din[c] = 16'($urandom);
      end
      if (n == 1700) begin
        #2 rst = 1'b1;
        tick();
        rst = 1'b0;
      end else begin
        tick();
      end
    end
    idle_all();
    tick();
    chk("c2 max count <= 6", int'(g_cfg[2].max_cnt <= 6), 1);
    chk("c0 max count <= 8", int'(g_cfg[0].max_cnt <= 8), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
